// File: rtl/commit_trace_buffer_if.sv
// Commit-record bus and trace-drain handshake for commit_trace_buffer.
// The master is the harness side (CPU commit + trace reader); the slave is the buffer.
interface commit_trace_buffer_if;
  logic         commit;
  logic [31:0]  commit_pc;
  logic [31:0]  commit_inst;
  logic         commit_halt;
  logic         commit_reg_we;
  logic [4:0]   commit_reg_wa;
  logic [31:0]  commit_reg_wd;
  logic         commit_dmem_we;
  logic [31:0]  commit_dmem_wa;
  logic [31:0]  commit_dmem_wd;
  logic         out_valid;
  logic         out_ready;
  logic [167:0] out_data;

  modport master (
    output commit, commit_pc, commit_inst, commit_halt,
    output commit_reg_we, commit_reg_wa, commit_reg_wd,
    output commit_dmem_we, commit_dmem_wa, commit_dmem_wd,
    output out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  commit, commit_pc, commit_inst, commit_halt,
    input  commit_reg_we, commit_reg_wa, commit_reg_wd,
    input  commit_dmem_we, commit_dmem_wa, commit_dmem_wd,
    input  out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Commit trace FIFO (first-word-fall-through) with retired/dropped counters and halt detection.
// Optional macro COMMIT_TRACE_FILTER_EN skips commits that have no architectural side effect.
module commit_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  commit_trace_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [15:0]              dropped_cnt,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic                     halted,
  output logic                     drained
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_RUN, S_HALTED, S_DRAINED} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q, level_d;
  logic              overflow_q;
  logic [15:0]       dropped_q;
  logic [CNT_W-1:0]  retired_q;
  logic [167:0]      mem_q [DEPTH];

  logic         keep;
  logic         in_run;
  logic         push_req;
  logic         pop;
  logic         push_ok;
  logic         drop;
  logic [167:0] record;

`ifdef COMMIT_TRACE_FILTER_EN
  assign keep = bus.commit_reg_we | bus.commit_dmem_we | bus.commit_halt;
`else
  assign keep = 1'b1;
`endif

  assign in_run   = (state_q == S_RUN);
  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = !empty && bus.out_ready;
  assign push_req = in_run && bus.commit && keep;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && !push_ok;

  assign record = {bus.commit_pc, bus.commit_inst, bus.commit_halt,
                   bus.commit_reg_we, bus.commit_reg_wa, bus.commit_reg_wd,
                   bus.commit_dmem_we, bus.commit_dmem_wa, bus.commit_dmem_wd};

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:     if (bus.commit && bus.commit_halt) state_d = S_HALTED;
      // Waiting on the registered empty makes drained trail empty by one cycle.
      S_HALTED:  if (empty) state_d = S_DRAINED;
      S_DRAINED: state_d = S_DRAINED;
      default:   state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
      retired_q  <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (drop) begin
        overflow_q <= 1'b1;
        dropped_q  <= sat_inc16(dropped_q);
      end
      if (in_run && bus.commit) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= record;
  end

  assign bus.out_valid = !empty;
  assign bus.out_data  = mem_q[rd_ptr_q];
  assign level         = level_q;
  assign overflow      = overflow_q;
  assign dropped_cnt   = dropped_q;
  assign retired_cnt   = retired_q;
  assign halted        = (state_q != S_RUN);
  assign drained       = (state_q == S_DRAINED);
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer (DEPTH=16): FIFO order, overflow, wrap, halt/drain, reset.
module tb_commit_trace_buffer;
  logic clk = 1'b0;
  logic rst;
  logic [4:0]  level;
  logic        full, empty, overflow, halted, drained;
  logic [15:0] dropped_cnt;
  logic [31:0] retired_cnt;
  int n_cmp = 0;
  int n_err = 0;

  commit_trace_buffer_if bus_if();

  commit_trace_buffer #(.DEPTH(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .level(level), .full(full), .empty(empty), .overflow(overflow),
    .dropped_cnt(dropped_cnt), .retired_cnt(retired_cnt),
    .halted(halted), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_if.commit = 0; bus_if.commit_pc = 0; bus_if.commit_inst = 0; bus_if.commit_halt = 0;
    bus_if.commit_reg_we = 0; bus_if.commit_reg_wa = 0; bus_if.commit_reg_wd = 0;
    bus_if.commit_dmem_we = 0; bus_if.commit_dmem_wa = 0; bus_if.commit_dmem_wd = 0;
  endtask

  // Drives one plain register-writing commit (kept in both builds) for one cycle.
  task automatic send(input logic [31:0] pc);
    idle();
    bus_if.commit = 1; bus_if.commit_pc = pc; bus_if.commit_inst = ~pc;
    bus_if.commit_reg_we = 1; bus_if.commit_reg_wa = 5'd1; bus_if.commit_reg_wd = pc;
    tick();
    idle();
  endtask

  task automatic do_reset();
    idle(); bus_if.out_ready = 0; rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_flags got empty=%b full=%b exp 1/0", empty, full); end
    n_cmp++; if (bus_if.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus_if.out_valid); end
    n_cmp++; if ({overflow, halted, drained} !== 3'b000 || retired_cnt !== 0 || dropped_cnt !== 0)
      begin n_err++; $display("FAIL reset_status got ov=%b h=%b d=%b ret=%0d drop=%0d exp all 0", overflow, halted, drained, retired_cnt, dropped_cnt); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    do_reset();
    send(32'h0040_0000);
    n_cmp++; if (bus_if.out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid got=%b exp=1", bus_if.out_valid); end
    send(32'h0040_0004);
    send(32'h0040_0008);
    n_cmp++; if (level !== 5'd3) begin n_err++; $display("FAIL basic_level got=%0d exp=3", level); end
    n_cmp++; if (retired_cnt !== 32'd3) begin n_err++; $display("FAIL basic_retired got=%0d exp=3", retired_cnt); end
    bus_if.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'h0040_0000 + 32'(4 * i);
      n_cmp++; if (bus_if.out_data[167:136] !== exp_pc) begin n_err++; $display("FAIL basic_pc%0d got=%h exp=%h", i, bus_if.out_data[167:136], exp_pc); end
      tick();
    end
    bus_if.out_ready = 0;
    n_cmp++; if (empty !== 1'b1 || level !== 5'd0) begin n_err++; $display("FAIL basic_empty got empty=%b level=%0d exp 1/0", empty, level); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) send(32'h0000_1000 + 32'(4 * i));
    n_cmp++; if (full !== 1'b1 || level !== 5'd16) begin n_err++; $display("FAIL ovf_full got full=%b level=%0d exp 1/16", full, level); end
    n_cmp++; if (overflow !== 1'b1 || dropped_cnt !== 16'd2) begin n_err++; $display("FAIL ovf_drop got ov=%b drop=%0d exp 1/2", overflow, dropped_cnt); end
    n_cmp++; if (retired_cnt !== 32'd18) begin n_err++; $display("FAIL ovf_retired got=%0d exp=18", retired_cnt); end
    n_cmp++; if (bus_if.out_data[167:136] !== 32'h0000_1000) begin n_err++; $display("FAIL ovf_head got=%h exp=00001000", bus_if.out_data[167:136]); end
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp_pc;
    bus_if.out_ready = 1;
    send(32'h0000_9000);
    n_cmp++; if (level !== 5'd16 || overflow !== 1'b1 || dropped_cnt !== 16'd2)
      begin n_err++; $display("FAIL pushpop_level got level=%0d ov=%b drop=%0d exp 16/1/2", level, overflow, dropped_cnt); end
    for (int i = 0; i < 16; i++) begin
      exp_pc = (i < 15) ? 32'h0000_1004 + 32'(4 * i) : 32'h0000_9000;
      n_cmp++; if (bus_if.out_data[167:136] !== exp_pc) begin n_err++; $display("FAIL wrap_pc%0d got=%h exp=%h", i, bus_if.out_data[167:136], exp_pc); end
      tick();
    end
    bus_if.out_ready = 0;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_halt();
    do_reset();
    idle();
    bus_if.commit = 1; bus_if.commit_pc = 32'h0000_0500; bus_if.commit_halt = 1;
    bus_if.commit_reg_we = 1; bus_if.commit_reg_wa = 5'd5; bus_if.commit_reg_wd = 32'hDEAD_BEEF;
    tick();
    idle();
    n_cmp++; if (halted !== 1'b1 || drained !== 1'b0) begin n_err++; $display("FAIL halt_flag got h=%b d=%b exp 1/0", halted, drained); end
    n_cmp++; if (bus_if.out_data[103] !== 1'b1 || bus_if.out_data[101:97] !== 5'd5 || bus_if.out_data[96:65] !== 32'hDEAD_BEEF)
      begin n_err++; $display("FAIL halt_record got h=%b wa=%0d wd=%h exp 1/5/deadbeef", bus_if.out_data[103], bus_if.out_data[101:97], bus_if.out_data[96:65]); end
    send(32'h0000_0600);
    n_cmp++; if (retired_cnt !== 32'd1 || level !== 5'd1) begin n_err++; $display("FAIL halt_ignore got ret=%0d level=%0d exp 1/1", retired_cnt, level); end
    bus_if.out_ready = 1;
    tick();
    bus_if.out_ready = 0;
    n_cmp++; if (empty !== 1'b1 || drained !== 1'b0) begin n_err++; $display("FAIL drain_early got empty=%b drained=%b exp 1/0", empty, drained); end
    tick();
    n_cmp++; if (drained !== 1'b1 || halted !== 1'b1) begin n_err++; $display("FAIL drain_late got drained=%b halted=%b exp 1/1", drained, halted); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) send(32'h0000_2000 + 32'(4 * i));
    idle(); bus_if.commit = 1; bus_if.commit_halt = 1; bus_if.commit_pc = 32'h0000_2018;
    tick(); idle();
    n_cmp++; if (level !== 5'd7 || halted !== 1'b1) begin n_err++; $display("FAIL mid_setup got level=%0d halted=%b exp 7/1", level, halted); end
    rst = 1; tick(); rst = 0;
    n_cmp++; if (level !== 5'd0 || halted !== 1'b0 || overflow !== 1'b0 || bus_if.out_valid !== 1'b0 || retired_cnt !== 0 || dropped_cnt !== 0)
      begin n_err++; $display("FAIL mid_reset got level=%0d h=%b ov=%b v=%b ret=%0d exp all 0", level, halted, overflow, bus_if.out_valid, retired_cnt); end
  endtask

  task automatic test_filter();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      idle();
      bus_if.commit = 1; bus_if.commit_pc = 32'h0000_3000 + 32'(4 * i);
      if (i == 1) begin
        bus_if.commit_dmem_we = 1; bus_if.commit_dmem_wa = 32'h1001_0004; bus_if.commit_dmem_wd = 32'h12;
      end
      tick();
    end
    idle();
    n_cmp++; if (retired_cnt !== 32'd4 || dropped_cnt !== 16'd0) begin n_err++; $display("FAIL filter_counts got ret=%0d drop=%0d exp 4/0", retired_cnt, dropped_cnt); end
`ifdef COMMIT_TRACE_FILTER_EN
    n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL filter_level got=%0d exp=1", level); end
    n_cmp++; if (bus_if.out_data[63:0] !== 64'h1001_0004_0000_0012) begin n_err++; $display("FAIL filter_data got=%h exp=1001000400000012", bus_if.out_data[63:0]); end
`else
    n_cmp++; if (level !== 5'd4) begin n_err++; $display("FAIL nofilter_level got=%0d exp=4", level); end
    n_cmp++; if (bus_if.out_data[167:136] !== 32'h0000_3000) begin n_err++; $display("FAIL nofilter_head got=%h exp=00003000", bus_if.out_data[167:136]); end
`endif
  endtask

  initial begin
    rst = 1;
    idle();
    bus_if.out_ready = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pushpop();
    test_halt();
    test_reset_mid();
    test_filter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
